// File: rtl/mem_access.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_access                                                 |
// | Description : MIPS32 memory-access stage. Loads and stores run over a    |
// |               single-outstanding req/ack bus. Non-memory ops pass        |
// |               straight through. Optional LL/SC link bit: MEM_LLSC_EN.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stall_req,
  output logic        excp_adel,
  output logic        excp_ades,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [7:0] c_exe_lb_op  = 8'b1110_0000;
  localparam logic [7:0] c_exe_lbu_op = 8'b1110_0100;
  localparam logic [7:0] c_exe_lh_op  = 8'b1110_0001;
  localparam logic [7:0] c_exe_lhu_op = 8'b1110_0101;
  localparam logic [7:0] c_exe_lw_op  = 8'b1110_0011;
  localparam logic [7:0] c_exe_sb_op  = 8'b1110_1000;
  localparam logic [7:0] c_exe_sh_op  = 8'b1110_1001;
  localparam logic [7:0] c_exe_sw_op  = 8'b1110_1011;
  localparam logic [7:0] c_exe_ll_op  = 8'b1111_0000;
  localparam logic [7:0] c_exe_sc_op  = 8'b1111_1000;

  localparam logic [1:0] c_size_byte = 2'd0;
  localparam logic [1:0] c_size_half = 2'd1;
  localparam logic [1:0] c_size_word = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  function automatic logic f_is_load(input logic [7:0] op);
    case (op)
      c_exe_lb_op, c_exe_lbu_op, c_exe_lh_op, c_exe_lhu_op,
      c_exe_lw_op, c_exe_ll_op: f_is_load = 1'b1;
      default:                  f_is_load = 1'b0;
    endcase
  endfunction

  function automatic logic f_is_store(input logic [7:0] op);
    case (op)
      c_exe_sb_op, c_exe_sh_op, c_exe_sw_op, c_exe_sc_op: f_is_store = 1'b1;
      default:                                            f_is_store = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] f_size(input logic [7:0] op);
    case (op)
      c_exe_lb_op, c_exe_lbu_op, c_exe_sb_op: f_size = c_size_byte;
      c_exe_lh_op, c_exe_lhu_op, c_exe_sh_op: f_size = c_size_half;
      default:                                f_size = c_size_word;
    endcase
  endfunction

  function automatic logic f_aligned(input logic [7:0] op, input logic [1:0] off);
    case (f_size(op))
      c_size_byte: f_aligned = 1'b1;
      c_size_half: f_aligned = ~off[0];
      default:     f_aligned = (off == 2'b00);
    endcase
  endfunction

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  function automatic logic [3:0] f_sel(input logic [7:0] op, input logic [1:0] off);
    case (f_size(op))
      c_size_byte: f_sel = 4'b1000 >> off;
      c_size_half: f_sel = off[1] ? 4'b0011 : 4'b1100;
      default:     f_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_store_data(input logic [7:0] op, input logic [31:0] d);
    case (f_size(op))
      c_size_byte: f_store_data = {4{d[7:0]}};
      c_size_half: f_store_data = {2{d[15:0]}};
      default:     f_store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] f_extract(input logic [7:0] op, input logic [1:0] off,
                                            input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[15:0] : d[31:16];
    case (op)
      c_exe_lb_op:  f_extract = {{24{b[7]}}, b};
      c_exe_lbu_op: f_extract = {24'd0, b};
      c_exe_lh_op:  f_extract = {{16{h[15]}}, h};
      c_exe_lhu_op: f_extract = {16'd0, h};
      default:      f_extract = d;
    endcase
  endfunction

  state_t      r_state;
  logic [31:0] r_rdata;
  logic [7:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_reg2;

  logic        w_in_mem;
  logic        w_in_aligned;
  logic        w_sc_fail;
  logic        w_issue;
  logic        w_bus_req;
  logic [7:0]  w_act_op;
  logic [31:0] w_act_addr;
  logic [31:0] w_act_reg2;
  logic [31:0] w_load_data;

`ifdef MEM_LLSC_EN
  logic r_llbit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_llbit <= 1'b0;
    end else if (flush) begin
      r_llbit <= 1'b0;
    end else if (r_state == S_DONE) begin
      if (r_op == c_exe_ll_op)
        r_llbit <= 1'b1;
      else if (r_op == c_exe_sc_op)
        r_llbit <= 1'b0;
    end
  end

  assign w_sc_fail = (mem_aluop == c_exe_sc_op) && !r_llbit;
`else
  assign w_sc_fail = 1'b0;
`endif

  assign w_in_mem     = f_is_load(mem_aluop) | f_is_store(mem_aluop);
  assign w_in_aligned = f_aligned(mem_aluop, mem_mem_addr[1:0]);
  assign w_issue      = (r_state == S_IDLE) && w_in_mem && w_in_aligned && !flush && !w_sc_fail;
  assign w_bus_req    = w_issue || (r_state == S_WAIT) || (r_state == S_ABORT);

  // The request cycle drives the bus from EX/MEM; later cycles replay the
  // captured copy so the bus stays stable even if EX/MEM moves on after a flush.
  assign w_act_op    = (r_state == S_IDLE) ? mem_aluop    : r_op;
  assign w_act_addr  = (r_state == S_IDLE) ? mem_mem_addr : r_addr;
  assign w_act_reg2  = (r_state == S_IDLE) ? mem_reg2     : r_reg2;
  assign w_load_data = f_extract(w_act_op, w_act_addr[1:0], bus_rdata);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rdata <= 32'd0;
      r_op    <= 8'd0;
      r_addr  <= 32'd0;
      r_reg2  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_op   <= mem_aluop;
            r_addr <= mem_mem_addr;
            r_reg2 <= mem_reg2;
            if (bus_ack) begin
              r_rdata <= w_load_data;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (flush) begin
            r_state <= bus_ack ? S_IDLE : S_ABORT;
          end else if (bus_ack) begin
            r_rdata <= w_load_data;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush || !stall)
            r_state <= S_IDLE;
        end
        S_ABORT: begin
          if (bus_ack)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held, including the passthrough path.
  always_comb begin
    wb_wd     = 5'd0;
    wb_wreg   = 1'b0;
    wb_wdata  = 32'd0;
    stall_req = 1'b0;
    excp_adel = 1'b0;
    excp_ades = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'd0;
    bus_sel   = 4'd0;
    bus_wdata = 32'd0;
    if (rst) begin
      bus_req = w_bus_req;
      if (w_bus_req) begin
        bus_we    = f_is_store(w_act_op);
        bus_addr  = {w_act_addr[31:2], 2'b00};
        bus_sel   = f_sel(w_act_op, w_act_addr[1:0]);
        bus_wdata = f_store_data(w_act_op, w_act_reg2);
      end
      wb_wd = mem_wd;
      case (r_state)
        S_IDLE: begin
          if (!w_in_mem) begin
            wb_wreg  = mem_wreg & ~flush;
            wb_wdata = mem_wdata;
          end else if (!w_in_aligned) begin
            excp_adel = ~flush & f_is_load(mem_aluop);
            excp_ades = ~flush & f_is_store(mem_aluop);
          end else if (w_sc_fail) begin
            wb_wreg  = ~flush;
            wb_wdata = 32'd0;
          end else begin
            stall_req = w_issue;
          end
        end
        S_WAIT, S_ABORT: begin
          stall_req = 1'b1;
        end
        S_DONE: begin
          if (r_op == c_exe_sc_op) begin
            wb_wreg  = ~flush;
            wb_wdata = 32'd1;
          end else if (f_is_load(r_op)) begin
            wb_wreg  = mem_wreg & ~flush;
            wb_wdata = r_rdata;
          end else begin
            wb_wdata = mem_wdata;
          end
        end
        default: stall_req = 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_access                                              |
// | Description : Directed self-checking bench for mem_access.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_access;

  localparam logic [7:0] c_add = 8'b0010_0000;
  localparam logic [7:0] c_lb  = 8'b1110_0000;
  localparam logic [7:0] c_lbu = 8'b1110_0100;
  localparam logic [7:0] c_lh  = 8'b1110_0001;
  localparam logic [7:0] c_lw  = 8'b1110_0011;
  localparam logic [7:0] c_sh  = 8'b1110_1001;
  localparam logic [7:0] c_sw  = 8'b1110_1011;
  localparam logic [7:0] c_ll  = 8'b1111_0000;
  localparam logic [7:0] c_sc  = 8'b1111_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        stall;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stall_req;
  logic        excp_adel;
  logic        excp_ades;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int n_cmp;
  int n_fail;

  mem_access dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .stall        (stall),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .wb_wd        (wb_wd),
    .wb_wreg      (wb_wreg),
    .wb_wdata     (wb_wdata),
    .stall_req    (stall_req),
    .excp_adel    (excp_adel),
    .excp_ades    (excp_ades),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_sel      (bus_sel),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input logic [31:0] addr,
                       input logic [31:0] reg2);
    mem_aluop    = op;
    mem_wd       = wd;
    mem_wreg     = wreg;
    mem_wdata    = wdata;
    mem_mem_addr = addr;
    mem_reg2     = reg2;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b0; flush = 1'b0; stall = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0;
    drive(c_add, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0);
    #12;
    check("rst_wb_wdata", wb_wdata, 32'd0);
    check("rst_wb_wreg", {31'd0, wb_wreg}, 32'd0);
    check("rst_wb_wd", {27'd0, wb_wd}, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);

    rst = 1'b1; #1;
    check("add_wdata", wb_wdata, 32'h1234);
    check("add_wd", {27'd0, wb_wd}, 32'd5);
    check("add_wreg", {31'd0, wb_wreg}, 32'd1);
    check("add_stall", {31'd0, stall_req}, 32'd0);
    check("add_req", {31'd0, bus_req}, 32'd0);

    // LB at 0x103, ack two cycles after the request
    tick(); drive(c_lb, 5'd3, 1'b1, 32'h0, 32'h103, 32'h0); bus_rdata = 32'h0000_00F0; #1;
    check("lb_req0", {31'd0, bus_req}, 32'd1);
    check("lb_sel0", {28'd0, bus_sel}, 32'h1);
    check("lb_addr0", bus_addr, 32'h100);
    check("lb_we0", {31'd0, bus_we}, 32'd0);
    check("lb_stall0", {31'd0, stall_req}, 32'd1);
    tick(); #1;
    check("lb_stall1", {31'd0, stall_req}, 32'd1);
    check("lb_req1", {31'd0, bus_req}, 32'd1);
    check("lb_sel1", {28'd0, bus_sel}, 32'h1);
    tick(); bus_ack = 1'b1; #1;
    check("lb_stall2", {31'd0, stall_req}, 32'd1);
    tick(); bus_ack = 1'b0; #1;
    check("lb_stall3", {31'd0, stall_req}, 32'd0);
    check("lb_req3", {31'd0, bus_req}, 32'd0);
    check("lb_wdata", wb_wdata, 32'hFFFF_FFF0);
    check("lb_wreg", {31'd0, wb_wreg}, 32'd1);

    // SH with same-cycle ack
    tick(); drive(c_sh, 5'd2, 1'b1, 32'h0, 32'h202, 32'hABCD_1234); bus_ack = 1'b1; #1;
    check("sh_req", {31'd0, bus_req}, 32'd1);
    check("sh_sel", {28'd0, bus_sel}, 32'h3);
    check("sh_bus_wdata", bus_wdata, 32'h1234_1234);
    check("sh_we", {31'd0, bus_we}, 32'd1);
    check("sh_addr", bus_addr, 32'h200);
    tick(); bus_ack = 1'b0; #1;
    check("sh_wreg", {31'd0, wb_wreg}, 32'd0);
    check("sh_stall", {31'd0, stall_req}, 32'd0);

    // misaligned load and store, then flush suppressing an aligned request
    tick(); drive(c_lw, 5'd4, 1'b1, 32'h0, 32'h101, 32'h0); #1;
    check("adel", {31'd0, excp_adel}, 32'd1);
    check("adel_req", {31'd0, bus_req}, 32'd0);
    check("adel_wreg", {31'd0, wb_wreg}, 32'd0);
    check("adel_stall", {31'd0, stall_req}, 32'd0);
    drive(c_sw, 5'd4, 1'b0, 32'h0, 32'h102, 32'h5); #1;
    check("ades", {31'd0, excp_ades}, 32'd1);
    check("ades_adel", {31'd0, excp_adel}, 32'd0);
    check("ades_req", {31'd0, bus_req}, 32'd0);
    drive(c_lw, 5'd4, 1'b1, 32'h0, 32'h300, 32'h0); flush = 1'b1; #1;
    check("fl_idle_req", {31'd0, bus_req}, 32'd0);
    check("fl_idle_stall", {31'd0, stall_req}, 32'd0);
    check("fl_idle_wreg", {31'd0, wb_wreg}, 32'd0);
    drive(c_add, 5'd1, 1'b1, 32'h0, 32'h0, 32'h0); flush = 1'b0;

    // LH same-cycle ack, then DONE held by stall while a stray ack is ignored
    tick(); drive(c_lh, 5'd6, 1'b1, 32'h0, 32'h200, 32'h0); bus_rdata = 32'h8001_7777; bus_ack = 1'b1; #1;
    check("lh_sel", {28'd0, bus_sel}, 32'hC);
    tick(); bus_ack = 1'b0; stall = 1'b1; #1;
    check("lh_wdata", wb_wdata, 32'hFFFF_8001);
    check("lh_stall", {31'd0, stall_req}, 32'd0);
    tick(); bus_rdata = 32'h0; bus_ack = 1'b1; stall = 1'b0; #1;
    check("lh_hold_wdata", wb_wdata, 32'hFFFF_8001);
    check("lh_hold_req", {31'd0, bus_req}, 32'd0);

    // LBU zero extension from lane 1
    tick(); drive(c_lbu, 5'd7, 1'b1, 32'h0, 32'h101, 32'h0); bus_rdata = 32'h11F2_3344; bus_ack = 1'b1; #1;
    check("lbu_sel", {28'd0, bus_sel}, 32'h4);
    tick(); bus_ack = 1'b0; #1;
    check("lbu_wdata", wb_wdata, 32'h0000_00F2);

    // flush in WAIT, ack arrives 3 cycles after the request
    tick(); drive(c_lw, 5'd8, 1'b1, 32'h0, 32'h300, 32'h0); #1;
    check("ab_req0", {31'd0, bus_req}, 32'd1);
    tick(); flush = 1'b1; #1;
    check("ab_req1", {31'd0, bus_req}, 32'd1);
    check("ab_stall1", {31'd0, stall_req}, 32'd1);
    check("ab_wreg1", {31'd0, wb_wreg}, 32'd0);
    tick(); flush = 1'b0; drive(c_add, 5'd7, 1'b1, 32'h55, 32'h0, 32'h0); #1;
    check("ab_req2", {31'd0, bus_req}, 32'd1);
    check("ab_addr2", bus_addr, 32'h300);
    check("ab_stall2", {31'd0, stall_req}, 32'd1);
    check("ab_wreg2", {31'd0, wb_wreg}, 32'd0);
    tick(); bus_ack = 1'b1; #1;
    check("ab_req3", {31'd0, bus_req}, 32'd1);
    check("ab_stall3", {31'd0, stall_req}, 32'd1);
    tick(); bus_ack = 1'b0; #1;
    check("ab_idle_wreg", {31'd0, wb_wreg}, 32'd1);
    check("ab_idle_wdata", wb_wdata, 32'h55);
    check("ab_idle_stall", {31'd0, stall_req}, 32'd0);
    check("ab_idle_req", {31'd0, bus_req}, 32'd0);

`ifdef MEM_LLSC_EN
    // SC without a link fails locally
    tick(); drive(c_sc, 5'd9, 1'b1, 32'h0, 32'h400, 32'hCAFE); #1;
    check("sc0_req", {31'd0, bus_req}, 32'd0);
    check("sc0_wdata", wb_wdata, 32'd0);
    check("sc0_wreg", {31'd0, wb_wreg}, 32'd1);
    check("sc0_stall", {31'd0, stall_req}, 32'd0);
    tick(); drive(c_ll, 5'd10, 1'b1, 32'h0, 32'h400, 32'h0); bus_rdata = 32'h77; bus_ack = 1'b1; #1;
    check("ll_req", {31'd0, bus_req}, 32'd1);
    tick(); bus_ack = 1'b0; #1;
    check("ll_wdata", wb_wdata, 32'h77);
    tick(); drive(c_sc, 5'd9, 1'b1, 32'h0, 32'h400, 32'hCAFE); bus_ack = 1'b1; #1;
    check("sc1_req", {31'd0, bus_req}, 32'd1);
    check("sc1_we", {31'd0, bus_we}, 32'd1);
    check("sc1_bus_wdata", bus_wdata, 32'hCAFE);
    tick(); bus_ack = 1'b0; #1;
    check("sc1_wdata", wb_wdata, 32'd1);
    check("sc1_wreg", {31'd0, wb_wreg}, 32'd1);
    tick(); drive(c_ll, 5'd10, 1'b1, 32'h0, 32'h400, 32'h0); bus_ack = 1'b1; #1;
    tick(); bus_ack = 1'b0; #1;
    tick(); drive(c_add, 5'd1, 1'b0, 32'h0, 32'h0, 32'h0); flush = 1'b1; #1;
    tick(); flush = 1'b0; drive(c_sc, 5'd9, 1'b1, 32'h0, 32'h400, 32'hCAFE); #1;
    check("sc2_req", {31'd0, bus_req}, 32'd0);
    check("sc2_wdata", wb_wdata, 32'd0);
    check("sc2_wreg", {31'd0, wb_wreg}, 32'd1);
`else
    // LL acts as LW; SC acts as SW returning 1
    tick(); drive(c_ll, 5'd10, 1'b1, 32'h0, 32'h400, 32'h0); bus_rdata = 32'h77; bus_ack = 1'b1; #1;
    check("ll_req", {31'd0, bus_req}, 32'd1);
    check("ll_sel", {28'd0, bus_sel}, 32'hF);
    tick(); bus_ack = 1'b0; #1;
    check("ll_wdata", wb_wdata, 32'h77);
    tick(); drive(c_sc, 5'd9, 1'b1, 32'h0, 32'h400, 32'hCAFE); bus_ack = 1'b1; #1;
    check("sc_req", {31'd0, bus_req}, 32'd1);
    check("sc_we", {31'd0, bus_we}, 32'd1);
    check("sc_bus_wdata", bus_wdata, 32'hCAFE);
    tick(); bus_ack = 1'b0; #1;
    check("sc_wdata", wb_wdata, 32'd1);
    check("sc_wreg", {31'd0, wb_wreg}, 32'd1);
`endif

    // asynchronous reset in the middle of a transaction
    tick(); drive(c_lw, 5'd8, 1'b1, 32'h0, 32'h500, 32'h0); #1;
    check("rm_req0", {31'd0, bus_req}, 32'd1);
    tick(); #1;
    check("rm_req_wait", {31'd0, bus_req}, 32'd1);
    rst = 1'b0; #1;
    check("rm_req", {31'd0, bus_req}, 32'd0);
    check("rm_stall", {31'd0, stall_req}, 32'd0);
    rst = 1'b1; drive(c_add, 5'd5, 1'b1, 32'h99, 32'h0, 32'h0); #1;
    check("rm_idle_wdata", wb_wdata, 32'h99);
    check("rm_idle_stall", {31'd0, stall_req}, 32'd0);
    check("rm_idle_req", {31'd0, bus_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
